// File: rtl/insert_debounce.sv
// Debounces a bouncing insert-sensor level and emits one fixed-width count pulse
// per accepted insert. Rejected press attempts are tallied in a saturating counter.
module insert_debounce #(
    parameter int DB_CYC = 4,
    parameter int PW     = 2,
    parameter int GW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          raw_in,
    output logic          pulse_out,
    output logic          held,
    output logic [GW-1:0] glitch_cnt
);

    localparam int CW  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int PCW = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYC - 1);
    localparam logic [PCW-1:0] PW_LAST = PCW'(PW - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t         state_reg, state_next;
    logic           sync_meta_reg;
    logic           sync_in;
    logic [CW-1:0]  db_cnt, db_cnt_next;
    logic [PCW-1:0] pulse_cnt_reg;
    logic           glitch_inc;
    logic           pulse_start;

    always_comb begin
        state_next  = state_reg;
        db_cnt_next = db_cnt;
        glitch_inc  = 1'b0;
        pulse_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sync_in) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sync_in) begin
                    state_next = IDLE;
                    glitch_inc = 1'b1;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = HELD;
                    pulse_start = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!sync_in) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sync_in) begin
                    state_next = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Every state change restarts the stability count.
        if (state_next != state_reg) db_cnt_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 1'b0;
            sync_in       <= 1'b0;
            state_reg     <= IDLE;
            db_cnt        <= '0;
            held          <= 1'b0;
            glitch_cnt    <= '0;
        end else begin
            sync_meta_reg <= raw_in;
            sync_in       <= sync_meta_reg;
            state_reg     <= state_next;
            db_cnt        <= db_cnt_next;
            held          <= (state_next == HELD) || (state_next == RELEASE_WAIT);
            if (glitch_inc && (glitch_cnt != '1)) glitch_cnt <= glitch_cnt + 1'b1;
        end
    end

    // Pulse timer runs independently of the FSM; a new start reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt_reg <= '0;
            pulse_out     <= 1'b0;
        end else if (pulse_start) begin
            pulse_cnt_reg <= PW_LAST;
            pulse_out     <= 1'b1;
        end else if (pulse_cnt_reg != '0) begin
            pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
            pulse_out     <= 1'b1;
        end else begin
            pulse_out     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_insert_debounce.sv
// Scoreboard bench for insert_debounce: a run-length reference model predicts
// held/pulse_out/glitch_cnt per edge; a monitor compares every post-reset cycle.
module tb_insert_debounce;

    localparam int DB_CYC = 4;
    localparam int PW     = 2;
    localparam int GW     = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          raw_in = 1'b1;
    logic          pulse_out;
    logic          held;
    logic [GW-1:0] glitch_cnt;

    always #5 clk = ~clk;

    insert_debounce #(.DB_CYC(DB_CYC), .PW(PW), .GW(GW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .pulse_out  (pulse_out),
        .held       (held),
        .glitch_cnt (glitch_cnt)
    );

    typedef struct packed {
        logic          pulse;
        logic          held;
        logic [GW-1:0] glitch;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model: the accepted level flips once the synchronized input has differed
    // from it for DB_CYC+1 consecutive samples; a short run of 1s while the
    // level is 0 counts as a rejected press.
    int m_level, m_run, m_pulse_left, m_glitch;

    task automatic model_reset();
        m_level = 0;
        m_run = 0;
        m_pulse_left = 0;
        m_glitch = 0;
    endtask

    task automatic model_step(input logic s);
        exp_t e;
        if (int'(s) == m_level) begin
            if (m_level == 0 && m_run > 0 && m_glitch < (1 << GW) - 1) m_glitch++;
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DB_CYC + 1) begin
                m_level = int'(s);
                m_run = 0;
                if (s) m_pulse_left = PW;
            end
        end
        e.pulse = (m_pulse_left > 0);
        if (m_pulse_left > 0) m_pulse_left--;
        e.held   = (m_level != 0);
        e.glitch = GW'(m_glitch);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Stimulus: one raw_in value per cycle, driven on the falling edge.
    task automatic drive(input logic v);
        @(negedge clk);
        raw_in = v;
        if (rst_n) model_step(v);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: the first two edges after reset only flush the synchronizer.
    initial begin
        int   n = 0;
        logic prev_pulse = 1'b0;
        exp_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                n = 0;
                prev_pulse = 1'b0;
            end else begin
                n++;
                a = {pulse_out, held, glitch_cnt};
                if (n <= 2) begin
                    check("post_reset", 32'(a), 32'(exp_t'(0)));
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("scoreboard", 32'(a), 32'(e));
                end
                if (pulse_out && !prev_pulse)
                    $display("insert pulse at edge %0d, glitch_cnt=%0d", n, glitch_cnt);
                prev_pulse = pulse_out;
            end
        end
    end

    initial begin
        bit found;
        model_reset();

        // Reset with raw_in=1 and no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_pulse", 32'(pulse_out), 32'd0);
        check("rst_async_held", 32'(held), 32'd0);
        check("rst_async_glitch", 32'(glitch_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_clocked_outs", 32'({pulse_out, held, glitch_cnt}), 32'd0);
        release_reset();

        // Clean press, release bounce, full release.
        repeat (20) drive(1'b1);
        check("clean_press_held", 32'(held), 32'd1);
        repeat (2) drive(1'b0);
        repeat (6) drive(1'b1);
        check("release_bounce_glitch", 32'(glitch_cnt), 32'd0);
        repeat (10) drive(1'b0);

        // Five press bounces saturate the 2-bit glitch counter.
        repeat (5) begin
            repeat (2) drive(1'b1);
            repeat (4) drive(1'b0);
        end
        repeat (3) drive(1'b0);
        @(posedge clk);
        #2;
        check("glitch_saturated", 32'(glitch_cnt), 32'd3);
        check("bounce_held_low", 32'(held), 32'd0);

        // Reset during the first pulse cycle, then a fresh press.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive(1'b1);
            @(posedge clk);
            #1;
            if (pulse_out) found = 1'b1;
        end
        check("pulse_seen_before_reset", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midpulse_rst_pulse", 32'(pulse_out), 32'd0);
        check("midpulse_rst_held", 32'(held), 32'd0);
        exp_q.delete();
        model_reset();
        release_reset();
        repeat (20) drive(1'b1);

        // Random bursts of varying length exercise accepts and bounces alike.
        for (int seg = 0; seg < 250; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            repeat (len) drive(lvl);
        end
        repeat (4) drive(raw_in);
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/insert_debounce.md
INSERT_DEBOUNCE -- requirements
Module: insert_debounce

Interface
REQ-001 Parameter DB_CYC, default 4: consecutive stable synchronized cycles required to accept a level change (legal range 1..65535).
REQ-002 Parameter PW, default 2: width of pulse_out in clk cycles (legal range 1..DB_CYC).
REQ-003 Parameter GW, default 8: width of glitch_cnt.
REQ-004 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port raw_in, input, 1: raw, bouncing, asynchronous insert-sensor level (1 = object present).
REQ-007 Port pulse_out, output, 1: registered clean pulse, one per accepted insert; drives the downstream insert counter's count input.
REQ-008 Port held, output, 1: registered debounced level of raw_in.
REQ-009 Port glitch_cnt, output, GW: saturating count of rejected press attempts.

Function
REQ-010 raw_in SHALL pass through a two-flop synchronizer; only the second flop (sync_in) SHALL feed the FSM.
REQ-011 The FSM SHALL have four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-012 Debounce counter db_cnt SHALL be wide enough to hold DB_CYC-1 and SHALL clear to 0 on every state change.
REQ-013 IDLE: sync_in=1 SHALL go to PRESS_WAIT; otherwise the FSM SHALL stay in IDLE.
REQ-014 PRESS_WAIT, sync_in=0: go to IDLE and increment glitch_cnt, saturating at all-ones.
REQ-015 PRESS_WAIT, sync_in=1, db_cnt==DB_CYC-1: go to HELD and start a pulse; otherwise increment db_cnt.
REQ-016 HELD: sync_in=0 SHALL go to RELEASE_WAIT; otherwise the FSM SHALL stay in HELD.
REQ-017 RELEASE_WAIT, sync_in=1: return to HELD with no new pulse and no glitch_cnt change.
REQ-018 RELEASE_WAIT, sync_in=0, db_cnt==DB_CYC-1: go to IDLE; otherwise increment db_cnt.
REQ-019 With DB_CYC=1, PRESS_WAIT SHALL go to HELD and RELEASE_WAIT SHALL go to IDLE on the first cycle sync_in is stable.
REQ-020 Latency: with raw_in rising before clk edge 1 and held stable, pulse_out and held SHALL both rise after edge DB_CYC+3.
REQ-021 pulse_out SHALL stay high for exactly PW cycles from a pulse start, independent of later FSM state changes.
REQ-022 If a pulse start coincides with an active pulse, the pulse length counter SHALL reload to PW; pulses SHALL never merge beyond PW cycles from the latest start.
REQ-023 held SHALL be 1 exactly when the state is HELD or RELEASE_WAIT, registered in the same cycle as the state.
REQ-024 Each insert accepted per REQ-015 SHALL produce exactly one pulse_out pulse.
REQ-025 Bounces during PRESS_WAIT or RELEASE_WAIT SHALL NOT produce a pulse.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, synchronizer=0, db_cnt=0, pulse length counter=0, pulse_out=0, held=0 and glitch_cnt=0.
REQ-027 Reset asserted mid-pulse or mid-debounce SHALL abort that operation with no residual pulse after release.
REQ-028 After rst_n deasserts, the first state update SHALL occur on the next rising clk edge.

Verification
REQ-029 Reset: drive rst_n=0 with raw_in=1 -> pulse_out=0, held=0 and glitch_cnt=0 throughout, with no clock required.
REQ-030 Clean press (DB_CYC=4, PW=2): raw_in=1 before edge 1, held for 20 cycles -> pulse_out=1 after edges 7 and 8, 0 after edge 9; held=1 from edge 7.
REQ-031 Press bounce: raw_in=1 for 2 cycles then 0 -> no pulse, glitch_cnt=1, held stays 0.
REQ-032 Release bounce: while held=1, raw_in=0 for 2 cycles then 1 -> held stays 1, no second pulse, glitch_cnt unchanged.
REQ-033 Mid-pulse reset: assert rst_n=0 in the first pulse_out cycle -> pulse_out=0 asynchronously; after release with raw_in=1 stable -> a fresh pulse DB_CYC+3 edges later.
REQ-034 Saturation (GW=2): 5 consecutive press bounces -> glitch_cnt=3 and held at 3.
